rgb2bayer_mosaic: RTL and testbench



---
 rtl/rgb2bayer_mosaic.sv | 174 +++++++++++++++++
 tb/tb_rgb2bayer_mosaic.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2bayer_mosaic.sv
// rgb2bayer_mosaic
//   Re-mosaicing encoder. Takes a raster-ordered RGB pixel stream and emits
//   one 8-bit Bayer sample per accepted pixel, picking R, G or B according to
//   the configured Bayer phase. Per-row horizontal blanking is inserted after
//   every row except the last, and one idle cycle follows the last pixel of a
//   frame, so downstream kernels get boundary time.
//
// Parameters
//   DATA_W   sample width (8)
//   width    active pixels per row
//   height   rows per frame
//   hBlank   idle cycles after each row except the last (0 allowed)
//   pattern  Bayer phase: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   iValid, iR/iG/iB      upstream pixel and its valid
//   oReady                pixel accepted this cycle when iValid is high
//   oData, oValid         Bayer sample, one cycle after acceptance
//   oNewFrame, oDone      pulses with the first / last sample of a frame
//   oXCnt, oYCnt          coordinates of the sample on oData
//   oOverrun              sticky: a pixel was offered while oReady was low
module rgb2bayer_mosaic #(
  parameter int DATA_W  = 8,
  parameter int width   = 320,
  parameter int height  = 240,
  parameter int hBlank  = 8,
  parameter int pattern = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iR,
  input  logic [DATA_W-1:0] iG,
  input  logic [DATA_W-1:0] iB,
  output logic              oReady,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              oNewFrame,
  output logic [31:0]       oXCnt,
  output logic [31:0]       oYCnt,
  output logic              oDone,
  output logic              oOverrun
);

  localparam logic [31:0] X_LAST    = 32'(width - 1);
  localparam logic [31:0] Y_LAST    = 32'(height - 1);
  localparam bit          HAS_BLANK = (hBlank > 0);
  // Last value of the blank counter before returning to ACTIVE; unused when
  // there is no blanking, but kept in range so the compare stays well formed.
  localparam logic [31:0] B_LAST    = HAS_BLANK ? 32'(hBlank - 1) : 32'd0;
  localparam logic [1:0]  PAT       = 2'(pattern);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HBLANK = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] xCnt;
  logic [31:0] yCnt;
  logic [31:0] blankCnt;
  logic        accept;
  logic        lastCol;
  logic        lastRow;
  logic [1:0]  phase;

  // Phase 00 is the red site, 11 the blue site, the two mixed phases green.
  function automatic logic [DATA_W-1:0] selectChannel(
    input logic [1:0]        ph,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] g,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] s;
    case (ph)
      2'b00:   s = r;
      2'b11:   s = b;
      default: s = g;
    endcase
    return s;
  endfunction

  assign accept  = iValid && oReady;
  assign lastCol = (xCnt == X_LAST);
  assign lastRow = (yCnt == Y_LAST);
  assign phase   = {yCnt[0] ^ PAT[1], xCnt[0] ^ PAT[0]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACTIVE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      ACTIVE: begin
        if (accept && lastCol) begin
          if (lastRow) begin
            stateNext = DONE;
          end else if (HAS_BLANK) begin
            stateNext = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (blankCnt == B_LAST) begin
          stateNext = ACTIVE;
        end
      end
      DONE:    stateNext = ACTIVE;
      default: stateNext = ACTIVE;
    endcase
  end

  // Output logic: reset overrides readiness in the same cycle.
  always_comb begin
    oReady = (state == ACTIVE) && !reset;
  end

  // Raster position and blanking counters
  always_ff @(posedge clk) begin
    if (reset) begin
      xCnt     <= 32'd0;
      yCnt     <= 32'd0;
      blankCnt <= 32'd0;
    end else begin
      if (accept) begin
        if (lastCol) begin
          xCnt <= 32'd0;
          yCnt <= lastRow ? 32'd0 : yCnt + 32'd1;
        end else begin
          xCnt <= xCnt + 32'd1;
        end
      end
      blankCnt <= (state == HBLANK) ? blankCnt + 32'd1 : 32'd0;
    end
  end

  // ---- stage boundary: accepted pixel -> registered Bayer sample ----
  // The sample register is cleared on reset as well, so an in-flight pixel
  // is dropped and oData reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      oData     <= '0;
      oValid    <= 1'b0;
      oNewFrame <= 1'b0;
      oDone     <= 1'b0;
      oXCnt     <= 32'd0;
      oYCnt     <= 32'd0;
      oOverrun  <= 1'b0;
    end else begin
      oValid    <= accept;
      oNewFrame <= accept && (xCnt == 32'd0) && (yCnt == 32'd0);
      oDone     <= accept && lastCol && lastRow;
      if (accept) begin
        oData <= selectChannel(phase, iR, iG, iB);
        oXCnt <= xCnt;
        oYCnt <= yCnt;
      end
      if (iValid && !oReady) begin
        oOverrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgb2bayer_mosaic.sv
// Bench for rgb2bayer_mosaic: three instances (RGGB with blanking, BGGR with
// blanking, RGGB without blanking) on a 4x2 frame, a cycle-level reference
// model built from pixel-count arithmetic, and literal expectations.
module tb_rgb2bayer_mosaic;

  localparam int W = 4;
  localparam int H = 2;
  localparam int HB[3] = '{2, 2, 0};
  localparam int PT[3] = '{0, 3, 0};
  // Colour at (x%2, y%2) for each pattern, index y*2+x: 0=R 1=G 2=B.
  localparam int COL[4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};

  logic       clk = 1'b0;
  logic       rst[3];
  logic       vld[3];
  logic [7:0] iR[3], iG[3], iB[3];
  logic       rdy[3], oV[3], nf[3], dn[3], ov[3];
  logic [7:0] oD[3];
  logic [31:0] xc[3], yc[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    rgb2bayer_mosaic #(
      .DATA_W(8), .width(W), .height(H), .hBlank(HB[g]), .pattern(PT[g])
    ) dut (
      .clk(clk), .reset(rst[g]), .iValid(vld[g]),
      .iR(iR[g]), .iG(iG[g]), .iB(iB[g]),
      .oReady(rdy[g]), .oData(oD[g]), .oValid(oV[g]), .oNewFrame(nf[g]),
      .oXCnt(xc[g]), .oYCnt(yc[g]), .oDone(dn[g]), .oOverrun(ov[g])
    );
  end

  int vecs = 0;
  int miss = 0;

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, i, $time, act, req);
    end
  endtask

  // Reference model state
  int         cycle = 0;
  bit         started[3];
  int         resume[3], kk[3], eX[3], eY[3];
  logic [7:0] eData[3];
  bit         eValid[3], eNF[3], eDone[3], eOvr[3], chkXY[3];

  // Captured output samples for literal checks
  logic [7:0] sData[3][32];
  int         sX[3][32], sY[3][32];
  bit         sNF[3][32], sDone[3][32];
  int         sN[3];
  int         nfCyc[4];
  int         nfN = 0;

  // Model + compare: at each falling edge, compare the outputs produced by
  // the last rising edge, then work out what the coming rising edge must do.
  initial begin
    int  x, y, c;
    bit  rdyM;
    for (int i = 0; i < 3; i++) begin
      started[i] = 0; sN[i] = 0;
    end
    forever begin
      @(negedge clk);
      cycle = cycle + 1;
      for (int i = 0; i < 3; i++) begin
        rdyM = (rst[i] !== 1'b1) && (cycle >= resume[i]);
        if (started[i]) begin
          check("oReady", i, rdy[i], rdyM);
          check("oValid", i, oV[i], eValid[i]);
          check("oData", i, oD[i], eData[i]);
          check("oNewFrame", i, nf[i], eNF[i]);
          check("oDone", i, dn[i], eDone[i]);
          check("oOverrun", i, ov[i], eOvr[i]);
          if (chkXY[i]) begin
            check("oXCnt", i, xc[i], eX[i]);
            check("oYCnt", i, yc[i], eY[i]);
          end
          if (oV[i] === 1'b1 && sN[i] < 32) begin
            sData[i][sN[i]] = oD[i];
            sX[i][sN[i]]    = int'(xc[i]);
            sY[i][sN[i]]    = int'(yc[i]);
            sNF[i][sN[i]]   = nf[i];
            sDone[i][sN[i]] = dn[i];
            sN[i]++;
          end
          if (i == 2 && nf[i] === 1'b1 && nfN < 4) begin
            nfCyc[nfN] = cycle;
            nfN++;
          end
        end
        if (rst[i] === 1'b1) begin
          started[i] = 1;
          eValid[i] = 0; eData[i] = 8'h00; eNF[i] = 0; eDone[i] = 0; eOvr[i] = 0;
          eX[i] = 0; eY[i] = 0; chkXY[i] = 1;
          kk[i] = 0; resume[i] = cycle + 1;
        end else if (started[i]) begin
          if (vld[i] && !rdyM) eOvr[i] = 1;
          if (vld[i] && rdyM) begin
            x = kk[i] % W;
            y = kk[i] / W;
            c = COL[PT[i]][(y % 2) * 2 + (x % 2)];
            eData[i]  = (c == 0) ? iR[i] : (c == 1) ? iG[i] : iB[i];
            eValid[i] = 1; eX[i] = x; eY[i] = y; chkXY[i] = 1;
            eNF[i]    = (kk[i] == 0);
            eDone[i]  = (kk[i] == W * H - 1);
            if (x == W - 1 && y == H - 1) begin
              kk[i] = 0; resume[i] = cycle + 2;
            end else begin
              if (x == W - 1) resume[i] = cycle + 1 + HB[i];
              kk[i]++;
            end
          end else begin
            eValid[i] = 0; eNF[i] = 0; eDone[i] = 0; chkXY[i] = 0;
          end
        end
      end
    end
  end

  // Stimulus
  int pixN[3];

  // One cycle for instance i: drive reset and pixel data just after the
  // rising edge, then raise iValid once readiness has settled.
  task automatic cyc(input int i, input bit r, input bit want, input bit onlyIfReady);
    @(posedge clk);
    #1;
    rst[i] = r;
    iR[i]  = 8'(pixN[i]);
    iG[i]  = 8'(8'h40 + pixN[i]);
    iB[i]  = 8'(8'h80 + pixN[i]);
    #1;
    vld[i] = want && (!onlyIfReady || rdy[i]);
    if (vld[i] && rdy[i]) pixN[i]++;
  endtask

  // mode 0: valid whenever ready, 1: toggle 1,0,..., 2: always valid, 3: idle
  task automatic drive(input int i, input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      cyc(i, 1'b0, (mode == 0) || (mode == 2) || (mode == 1 && k % 2 == 0), mode != 2);
    end
  endtask

  task automatic doReset(input int i, input int n);
    pixN[i] = 0;
    for (int k = 0; k < n; k++) cyc(i, 1'b1, 1'b0, 1'b1);
    pixN[i] = 0;
  endtask

  localparam logic [7:0] LIT_A[8] = '{8'h00, 8'h41, 8'h02, 8'h43, 8'h44, 8'h85, 8'h46, 8'h87};
  localparam logic [7:0] LIT_B[8] = '{8'h80, 8'h41, 8'h82, 8'h43, 8'h44, 8'h05, 8'h46, 8'h07};

  initial begin
    int rowOne;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; iR[i] = 8'h00; iG[i] = 8'h00; iB[i] = 8'h00; pixN[i] = 0;
    end

    // RGGB, hBlank=2, continuous frame
    doReset(0, 2);
    sN[0] = 0;
    drive(0, 11, 0);
    drive(0, 2, 3);
    check("frameA.count", 0, sN[0], 8);
    for (int k = 0; k < 8; k++) check("frameA.data", k, sData[0][k], LIT_A[k]);
    check("frameA.newFrame", 0, sNF[0][0], 1);
    check("frameA.done", 0, sDone[0][7], 1);

    // toggling iValid
    doReset(0, 1);
    sN[0] = 0;
    drive(0, 9, 1);
    drive(0, 1, 3);
    check("toggle.count", 0, sN[0], 4);
    for (int k = 0; k < 4; k++) check("toggle.xcnt", k, sX[0][k], k);
    check("toggle.overrun", 0, ov[0], 0);

    // iValid held high through blanking
    doReset(0, 1);
    sN[0] = 0;
    drive(0, 11, 2);
    drive(0, 1, 3);
    rowOne = 0;
    for (int k = 0; k < sN[0]; k++) if (sY[0][k] == 1) rowOne++;
    check("overrun.row1count", 0, rowOne, 4);
    check("overrun.sticky", 0, ov[0], 1);

    // reset after three accepted pixels
    drive(0, 3, 0);
    doReset(0, 2);
    check("midReset.overrun", 0, ov[0], 0);
    sN[0] = 0;
    drive(0, 4, 0);
    drive(0, 1, 3);
    check("midReset.x", 0, sX[0][0], 0);
    check("midReset.y", 0, sY[0][0], 0);
    check("midReset.newFrame", 0, sNF[0][0], 1);

    // BGGR frame
    doReset(1, 2);
    sN[1] = 0;
    drive(1, 11, 0);
    drive(1, 2, 3);
    check("frameB.count", 1, sN[1], 8);
    for (int k = 0; k < 8; k++) check("frameB.data", k, sData[1][k], LIT_B[k]);

    // hBlank=0, two back-to-back frames
    doReset(2, 2);
    nfN = 0;
    sN[2] = 0;
    drive(2, 18, 0);
    drive(2, 2, 3);
    check("frameC.newFrames", 2, nfN, 2);
    check("frameC.gap", 2, nfCyc[1] - nfCyc[0], 9);
    check("frameC.count", 2, sN[2], 16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
